mlp_pe: RTL and testbench

- Processing element for the MLP neuron datapath.
- Each accepted cycle it multiply-accumulates two packed signed Q8.8 input/weight lanes into a wide accumulator.
- Intermediate partial sums can be parked in a small internal FIFO and resumed later.
- Finished sums pass through ReLU and saturate to a 16-bit Q8.8 neuron output.

---
 rtl/mlp_pkg.sv | 11 +
 rtl/mlp_psum_fifo.sv | 49 ++++
 rtl/mlp_pe.sv | 81 ++++++++
 tb/tb_mlp_pe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared fixed-point constants and types for the MLP neuron datapath.
package mlp_pkg;
    localparam int          FRAC_BITS      = 8;
    localparam logic [15:0] Q_ONE          = 16'h0100;
    localparam logic [15:0] SAT_MAX        = 16'h7FFF;
    localparam int          ACC_W_DEF      = 40;
    localparam int          PSUM_DEPTH_DEF = 4;

    typedef logic signed [15:0]          q88_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;
endpackage

// File: rtl/mlp_psum_fifo.sv
// Partial-sum FIFO: head is visible combinationally, pops on empty and pushes on full are ignored.
module mlp_psum_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rptr, r_wptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop, w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (reset && w_do_push) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mlp_pe.sv
// MLP processing element: 2-lane Q8.8 MAC into a wide accumulator, partial-sum parking,
// and a ReLU + saturating Q8.8 output register.
module mlp_pe
    import mlp_pkg::*;
#(
    parameter int PSUM_DEPTH = PSUM_DEPTH_DEF,
    parameter int ACC_W      = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] input_data,
    input  logic [31:0] weight,
    input  logic        read_enable,
    input  logic        mux_select,
    input  logic        write_enable,
    input  logic        demux_select,
    output logic [15:0] pe_out
);
    q88_t                    w_a0, w_a1, w_b0, w_b1;
    logic signed [31:0]      w_p0, w_p1;
    logic signed [32:0]      w_sum;
    logic signed [ACC_W-1:0] r_prod, r_acc, w_head, w_base, w_shift;
    logic                    r_prod_v, w_full, w_empty, w_pop, w_push;
    logic [15:0]             r_pe_out, w_sat;

    assign w_a0  = input_data[15:0];
    assign w_a1  = input_data[31:16];
    assign w_b0  = weight[15:0];
    assign w_b1  = weight[31:16];
    assign w_p0  = w_a0 * w_b0;
    assign w_p1  = w_a1 * w_b1;
    assign w_sum = {w_p0[31], w_p0} + {w_p1[31], w_p1};

    assign w_pop  = r_prod_v & mux_select;
    assign w_push = write_enable & demux_select;

    mlp_psum_fifo #(.DEPTH(PSUM_DEPTH), .W(ACC_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_acc),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A flush in the same cycle as an accumulate restarts the sum from zero.
    always_comb begin
        w_base = r_acc;
        if (mux_select)        w_base = w_empty ? '0 : w_head;
        else if (write_enable) w_base = '0;
    end

    assign w_shift = r_acc >>> FRAC_BITS;
    always_comb begin
        w_sat = w_shift[15:0];
        if (r_acc[ACC_W-1])             w_sat = '0;
        else if (|w_shift[ACC_W-1:15])  w_sat = SAT_MAX;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prod   <= '0;
            r_prod_v <= 1'b0;
            r_acc    <= '0;
            r_pe_out <= '0;
        end else begin
            r_prod_v <= read_enable;
            if (read_enable)  r_prod <= {{(ACC_W-33){w_sum[32]}}, w_sum};
            if (r_prod_v)     r_acc  <= w_base + r_prod;
            else if (write_enable) r_acc <= '0;
            if (write_enable && !demux_select) r_pe_out <= w_sat;
        end
    end

    assign pe_out = r_pe_out;

    logic w_unused;
    assign w_unused = w_full;
endmodule

// File: tb/tb_mlp_pe.sv
// Self-checking bench for mlp_pe: table-driven MAC vectors plus FIFO/flush corner sequences.
module tb_mlp_pe;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] input_data, weight;
    logic        read_enable, mux_select, write_enable, demux_select;
    logic [15:0] pe_out;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    localparam logic [31:0] BD = 32'h0100_0200;
    localparam logic [31:0] BW = 32'h0100_0300;

    mlp_pe #(.PSUM_DEPTH(4), .ACC_W(40)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .weight       (weight),
        .read_enable  (read_enable),
        .mux_select   (mux_select),
        .write_enable (write_enable),
        .demux_select (demux_select),
        .pe_out       (pe_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] w;
        int          n;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic rd, input logic [31:0] d, input logic [31:0] w,
                        input logic mx, input logic we, input logic dm);
        read_enable = rd; input_data = d; weight = w;
        mux_select = mx; write_enable = we; demux_select = dm;
        @(posedge clk); #1;
    endtask

    task automatic flush0(input logic [15:0] exp, input string name);
        exp_q.push_back(exp);
        step(0, '0, '0, 0, 1, 0);
        chk(name, 64'(pe_out), 64'(exp_q.pop_front()));
    endtask

    task automatic park(input logic [31:0] d, input logic [31:0] w);
        step(1, d, w, 0, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        step(0, '0, '0, 0, 1, 1);
    endtask

    task automatic pop_into(input logic [31:0] d, input logic [31:0] w);
        step(1, d, w, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        read_enable = 0; mux_select = 0; write_enable = 0; demux_select = 0;
        input_data = '0; weight = '0;
        vt[0] = '{BD, BW, 1, 16'h0700};
        vt[1] = '{BD, BW, 3, 16'h1500};
        vt[2] = '{32'h0000_FF00, 32'h0000_0100, 1, 16'h0000};
        vt[3] = '{32'h7FFF_7FFF, 32'h7FFF_7FFF, 4, 16'h7FFF};
        vt[4] = '{32'h0080_0080, 32'h0100_0100, 1, 16'h0100};
        vt[5] = '{32'h0000_0003, 32'h0000_0155, 1, 16'h0003};
        vt[6] = '{32'hFE00_FE00, 32'hFF00_FF00, 1, 16'h0400};
        vt[7] = '{32'h0100_0300, 32'hFE00_0100, 1, 16'h0100};
        vt[8] = '{32'h0000_7F00, 32'h0000_0100, 1, 16'h7F00};
        vt[9] = '{32'h0000_0180, 32'h0000_0180, 2, 16'h0480};

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        chk("rst_pe_out", 64'(pe_out), 64'h0);
        chk("rst_count", 64'(dut.u_fifo.r_count), 64'h0);
        reset = 1'b1;
        flush0(16'h0000, "rst_flush");

        foreach (vt[i]) begin
            for (int k = 0; k < vt[i].n; k++) step(1, vt[i].d, vt[i].w, 0, 0, 0);
            step(0, '0, '0, 0, 0, 0);
            flush0(vt[i].exp, $sformatf("vec%0d", i));
        end

        // pe_out holds across idles and FIFO-directed flushes
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, 0, 0);
        chk("hold_idle", 64'(pe_out), 64'h0480);
        park(BD, BW);
        chk("hold_park", 64'(pe_out), 64'h0480);
        chk("park_count", 64'(dut.u_fifo.r_count), 64'h1);
        chk("park_acc", 64'(dut.r_acc), 64'h0);
        pop_into(BD, BW);
        flush0(16'h0E00, "resume");
        chk("resume_count", 64'(dut.u_fifo.r_count), 64'h0);

        // Overfill: fifth push is dropped
        for (int i = 1; i <= 5; i++) park(32'(i) << 8, 32'h0000_0100);
        chk("full_count", 64'(dut.u_fifo.r_count), 64'h4);
        for (int i = 1; i <= 4; i++) begin
            pop_into('0, '0);
            flush0(16'(i << 8), $sformatf("drain%0d", i));
        end
        pop_into(BD, BW);
        flush0(16'h0700, "pop_empty");
        chk("empty_count", 64'(dut.u_fifo.r_count), 64'h0);

        // Push and pop together on a full FIFO
        for (int i = 1; i <= 4; i++) park(32'(i) << 8, 32'h0000_0100);
        step(1, '0, '0, 0, 0, 0);
        step(0, '0, '0, 1, 1, 1);
        chk("pp_full_count", 64'(dut.u_fifo.r_count), 64'h4);
        flush0(16'h0100, "pp_full_acc");
        for (int i = 2; i <= 5; i++) begin
            pop_into('0, '0);
            flush0(i == 5 ? 16'h0000 : 16'(i << 8), $sformatf("pp_drain%0d", i));
        end

        // Push and pop together on an empty FIFO
        step(1, BD, BW, 0, 0, 0);
        step(0, '0, '0, 1, 1, 1);
        chk("pp_empty_count", 64'(dut.u_fifo.r_count), 64'h1);
        flush0(16'h0700, "pp_empty_acc");
        pop_into('0, '0);
        flush0(16'h0000, "pp_empty_pop");

        // Flush lands on the same edge as a new product
        step(1, BD, BW, 0, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        step(1, 32'h0000_0100, 32'h0000_0200, 0, 0, 0);
        exp_q.push_back(16'h0700);
        step(0, '0, '0, 0, 1, 0);
        chk("sim_pe_out", 64'(pe_out), 64'(exp_q.pop_front()));
        chk("sim_acc", 64'(dut.r_acc), 64'h2_0000);
        flush0(16'h0200, "sim_next");

        // Reset mid-operation drops in-flight work and FIFO contents
        park(BD, BW);
        step(1, BD, BW, 0, 0, 0);
        reset = 1'b0;
        step(1, BD, BW, 1, 1, 1);
        reset = 1'b1;
        chk("mid_rst_pe_out", 64'(pe_out), 64'h0);
        chk("mid_rst_count", 64'(dut.u_fifo.r_count), 64'h0);
        chk("mid_rst_prod_v", 64'(dut.r_prod_v), 64'h0);
        step(0, '0, '0, 0, 0, 0);
        flush0(16'h0000, "mid_rst_flush");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
